id_ex_elastic_reg: RTL

//  Parametrised ID->EX pipeline register with valid/ready handshake, stall absorption and flush.

---
 rtl/id_ex_pkg.sv | 53 +++++
 rtl/id_ex_entry_reg.sv | 36 +++
 rtl/id_ex_elastic_reg.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared types for the ID->EX elastic pipeline register.
//  ctrl_t  : decoded control bundle {RegWrite,MemWrite,Jump,Branch,ALUSrc,ResultSrc,ALUControl}
//  entry_t : one held instruction (control, register addresses, datapath payload)
//  state_t : occupancy of the stage (EMPTY, ONE = main full, TWO = main+skid full)
// The PKG_* widths fix the struct layout.
package id_ex_pkg;

    localparam int PKG_XLEN      = 32;
    localparam int PKG_REG_AW    = 5;
    localparam int PKG_ALUCTRL_W = 3;
    localparam int PKG_RESSRC_W  = 2;

    typedef struct packed {
        logic                     reg_write;
        logic                     mem_write;
        logic                     jump;
        logic                     branch;
        logic                     alu_src;
        logic [PKG_RESSRC_W-1:0]  result_src;
        logic [PKG_ALUCTRL_W-1:0] alu_control;
    } ctrl_t;

    typedef struct packed {
        ctrl_t                 ctrl;
        logic [PKG_REG_AW-1:0] rs1;
        logic [PKG_REG_AW-1:0] rs2;
        logic [PKG_REG_AW-1:0] rd;
        logic [PKG_XLEN-1:0]   rd1;
        logic [PKG_XLEN-1:0]   rd2;
        logic [PKG_XLEN-1:0]   pc;
        logic [PKG_XLEN-1:0]   imm;
        logic [PKG_XLEN-1:0]   pcplus4;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Clear the state-writing enables of a control bundle when it is not live,
    // so a bubble can never write the register file or memory or redirect fetch.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic live);
        ctrl_t g;
        g           = c;
        g.reg_write = c.reg_write & live;
        g.mem_write = c.mem_write & live;
        g.jump      = c.jump      & live;
        g.branch    = c.branch    & live;
        return g;
    endfunction

endpackage

// File: rtl/id_ex_entry_reg.sv
// id_ex_entry_reg: one entry_t storage register with load enable.
//  clk, reset  : clock (rising edge), asynchronous active-high reset to all zeros
//  load_en     : capture entry_in at the next rising edge
//  entry_in    : entry to capture
//  entry_out   : currently held entry (unchanged while load_en is low)
module id_ex_entry_reg
    import id_ex_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load_en,
    input  entry_t entry_in,
    output entry_t entry_out
);

    entry_t entry_d;
    entry_t entry_q;

    always_comb begin
        entry_d = entry_q;
        if (load_en) begin
            entry_d = entry_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_out = entry_q;

endmodule

// File: rtl/id_ex_elastic_reg.sv
// id_ex_elastic_reg: ID->EX pipeline register with valid/ready handshake,
// stall absorption and flush.
//  clk, reset           : clock (rising edge), asynchronous active-high reset
//  flush                : synchronous kill of every held entry; a same-cycle push is dropped
//  in_valid / in_ready  : decode-side handshake (push = in_valid & in_ready)
//  ctrl_d ... pcplus4_d : decoded instruction presented by decode
//  out_valid / out_ready: execute-side handshake (pop = out_valid & out_ready)
//  ctrl_e ... pcplus4_e : head entry; state-writing enables of ctrl_e are 0 when !out_valid
// SKID=1 adds a second entry so in_ready is a pure decode of the state register and
// full throughput survives a registered ready. SKID=0 is a single register whose
// in_ready looks through to out_ready.
// The XLEN/REG_AW/ALUCTRL_W/RESSRC_W parameters must match the id_ex_pkg widths,
// since the held entry is the package struct.
module id_ex_elastic_reg
    import id_ex_pkg::*;
#(
    parameter int XLEN      = PKG_XLEN,
    parameter int REG_AW    = PKG_REG_AW,
    parameter int ALUCTRL_W = PKG_ALUCTRL_W,
    parameter int RESSRC_W  = PKG_RESSRC_W,
    parameter bit SKID      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  ctrl_t             ctrl_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic [XLEN-1:0]   pcplus4_d,

    output logic              out_valid,
    input  logic              out_ready,
    output ctrl_t             ctrl_e,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   pcplus4_e
);

    state_t state_d;
    state_t state_q;

    entry_t in_entry;
    entry_t main_in;
    entry_t main_q;
    entry_t skid_q;

    logic push;
    logic pop;
    logic main_ld;
    logic main_from_skid;
    logic skid_ld;

    assign in_entry = '{ctrl:    ctrl_d,
                        rs1:     rs1_d,
                        rs2:     rs2_d,
                        rd:      rd_d,
                        rd1:     rd1_d,
                        rd2:     rd2_d,
                        pc:      pc_d,
                        imm:     imm_d,
                        pcplus4: pcplus4_d};

    assign out_valid = (state_q != EMPTY);

    generate
        if (SKID) begin : g_rdy_skid
            assign in_ready = (state_q != TWO);
        end else begin : g_rdy_flow
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Next state and entry load enables.
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    main_ld = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_ld = 1'b1;
                end else if (push) begin
                    // Only reachable with the skid entry: SKID=0 cannot push into a
                    // full stage unless the head is leaving.
                    if (SKID) begin
                        state_d = TWO;
                        skid_ld = 1'b1;
                    end
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so the only movement is skid -> main.
                if (pop) begin
                    state_d        = ONE;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush overrides everything; stale payload may stay in the registers since
        // out_valid and the gated enables hide it.
        if (flush) begin
            state_d = EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_in = main_from_skid ? skid_q : in_entry;

    id_ex_entry_reg u_main (
        .clk       (clk),
        .reset     (reset),
        .load_en   (main_ld),
        .entry_in  (main_in),
        .entry_out (main_q)
    );

    generate
        if (SKID) begin : g_skid
            id_ex_entry_reg u_skid (
                .clk       (clk),
                .reset     (reset),
                .load_en   (skid_ld),
                .entry_in  (in_entry),
                .entry_out (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    assign ctrl_e    = gate_ctrl(main_q.ctrl, out_valid);
    assign rs1_e     = main_q.rs1;
    assign rs2_e     = main_q.rs2;
    assign rd_e      = main_q.rd;
    assign rd1_e     = main_q.rd1;
    assign rd2_e     = main_q.rd2;
    assign pc_e      = main_q.pc;
    assign imm_e     = main_q.imm;
    assign pcplus4_e = main_q.pcplus4;

endmodule
